// File: rtl/uart_bus_responder_pkg.sv
// Shared constants, state encodings and helpers for the CPU-bus UART responder.
// The RX FIFO depth here is only used when UART_RX_FIFO_EN is defined.
package uart_bus_responder_pkg;

  localparam int UART_CLK_HZ = 50_000_000;
  localparam int UART_BAUD   = 115_200;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int UART_DIV           = uart_div(UART_CLK_HZ, UART_BAUD);
  localparam int UART_RX_FIFO_DEPTH = 4;

  // Upper byte presented on the 16-bit bus during a read
  localparam logic [7:0] UART_BUS_READ_PAD = 8'h00;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous RX byte FIFO with registered pointers; head is read combinationally.
// Only instantiated when UART_RX_FIFO_EN is defined. DEPTH must be a power of 2.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk_50MHz) begin
    if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Caller guarantees push only when not full (or when popping) and pop only when not empty
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = ({~r_wr_ptr[AW], r_wr_ptr[AW-1:0]} == r_rd_ptr);

endmodule

// File: rtl/uart_bus_responder.sv
// CPU parallel-bus front end for an 8N1 UART: THR/TSR transmitter, synchronised receiver.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO instead of a single RHR.
module uart_bus_responder
  import uart_bus_responder_pkg::*;
#(
  parameter int CLK_HZ        = UART_CLK_HZ,
  parameter int BAUD          = UART_BAUD,
  parameter int RX_FIFO_DEPTH = UART_RX_FIFO_DEPTH
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  inout  wire  [15:0] bus_data,
  input  logic        rdn,
  input  logic        wrn,
  output logic        data_ready,
  output logic        tbre,
  output logic        tsre,
  output logic        txd,
  input  logic        rxd,
  output logic        rx_overrun
);

  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  // ---------------- bus strobes ----------------
  logic r_rdn_q, r_wrn_q;
  logic w_wr_edge, w_rd_done;
  logic w_unused_bus_hi;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_rdn_q <= 1'b1;
      r_wrn_q <= 1'b1;
    end else begin
      r_rdn_q <= rdn;
      r_wrn_q <= wrn;
    end
  end

  assign w_wr_edge       = !wrn && r_wrn_q;
  assign w_rd_done       = rdn && !r_rdn_q;
  assign w_unused_bus_hi = ^bus_data[15:8];

  // ---------------- transmitter ----------------
  tx_state_t        r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]       r_tx_bit, w_tx_bit_next;
  logic [7:0]       r_tsr, w_tsr_next;
  logic [7:0]       r_thr;
  logic             r_tbre, r_tsre, r_txd;
  logic             w_txd_next, w_tx_load, w_tx_done, w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_next   = r_tx_bit;
    w_tsr_next      = r_tsr;
    w_tx_load       = 1'b0;
    w_tx_done       = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        w_tx_cnt_next = '0;
        if (!r_tbre) begin
          w_tx_load       = 1'b1;
          w_tsr_next      = r_thr;
          w_tx_state_next = T_START;
        end
      end
      T_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_bit_next   = 3'd0;
          w_tx_state_next = T_DATA;
        end
      end
      T_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next = '0;
          w_tsr_next    = {1'b0, r_tsr[7:1]};
          if (r_tx_bit == 3'd7) w_tx_state_next = T_STOP;
          else                  w_tx_bit_next   = r_tx_bit + 3'd1;
        end
      end
      T_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next = '0;
          // A byte already waiting in THR follows with no idle gap
          if (!r_tbre) begin
            w_tx_load       = 1'b1;
            w_tsr_next      = r_thr;
            w_tx_state_next = T_START;
          end else begin
            w_tx_done       = 1'b1;
            w_tx_state_next = T_IDLE;
          end
        end
      end
      default: begin
        w_tx_cnt_next   = '0;
        w_tx_state_next = T_IDLE;
      end
    endcase
    case (w_tx_state_next)
      T_START: w_txd_next = 1'b0;
      T_DATA:  w_txd_next = w_tsr_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tsr      <= 8'h00;
      r_thr      <= 8'h00;
      r_tbre     <= 1'b1;
      r_tsre     <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tsr      <= w_tsr_next;
      r_txd      <= w_txd_next;
      if (w_tx_load) begin
        r_tbre <= 1'b1;
      end else if (w_wr_edge && r_tbre) begin
        r_tbre <= 1'b0;
        r_thr  <= bus_data[7:0];
      end
      if (w_tx_load)      r_tsre <= 1'b0;
      else if (w_tx_done) r_tsre <= 1'b1;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t        r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]       r_rx_bit, w_rx_bit_next;
  logic [7:0]       r_rx_shift, w_rx_shift_next;
  logic             r_rxd_s1, r_rxd_s2, r_rxd_prev;
  logic             w_rx_fall, w_rx_valid;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_s1   <= rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
    end
  end

  assign w_rx_fall = r_rxd_prev && !r_rxd_s2;

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_valid      = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        w_rx_cnt_next = '0;
        if (w_rx_fall) w_rx_state_next = R_START;
      end
      R_START: begin
        // Re-check the line at mid start bit to reject short glitches
        if (r_rx_cnt == CNT_HALF) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = 3'd0;
          w_rx_state_next = r_rxd_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rxd_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_next = R_STOP;
          else                  w_rx_bit_next   = r_rx_bit + 3'd1;
        end
      end
      R_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_valid      = r_rxd_s2;
          w_rx_state_next = R_IDLE;
        end
      end
      default: begin
        w_rx_cnt_next   = '0;
        w_rx_state_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
    end
  end

  // ---------------- receive buffer ----------------
  logic [7:0] w_rd_byte;
  logic       w_data_ready;
  logic       w_overrun_set;
  logic       r_rx_overrun;

`ifdef UART_RX_FIFO_EN
  logic w_fifo_empty, w_fifo_full, w_fifo_pop, w_fifo_push;

  assign w_fifo_pop    = w_rd_done && !w_fifo_empty;
  assign w_fifo_push   = w_rx_valid && (!w_fifo_full || w_fifo_pop);
  assign w_overrun_set = w_rx_valid && w_fifo_full && !w_fifo_pop;
  assign w_data_ready  = !w_fifo_empty;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .i_push    (w_fifo_push),
    .i_data    (r_rx_shift),
    .i_pop     (w_fifo_pop),
    .o_head    (w_rd_byte),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );
`else
  logic [7:0] r_rhr;
  logic       r_data_ready;
  logic       w_unused_fifo_cfg;

  assign w_unused_fifo_cfg = (RX_FIFO_DEPTH > 0);
  assign w_overrun_set     = w_rx_valid && r_data_ready && !w_rd_done;
  assign w_data_ready      = r_data_ready;
  assign w_rd_byte         = r_rhr;

  // A read completing on the same edge frees the RHR for the new byte
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_rhr        <= 8'h00;
      r_data_ready <= 1'b0;
    end else if (w_rx_valid && (!r_data_ready || w_rd_done)) begin
      r_rhr        <= r_rx_shift;
      r_data_ready <= 1'b1;
    end else if (w_rd_done) begin
      r_data_ready <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst)               r_rx_overrun <= 1'b0;
    else if (w_overrun_set) r_rx_overrun <= 1'b1;
    else if (w_rd_done)     r_rx_overrun <= 1'b0;
  end

  // ---------------- outputs ----------------
  assign bus_data   = !rdn ? {UART_BUS_READ_PAD, w_rd_byte} : 16'hzzzz;
  assign data_ready = w_data_ready;
  assign rx_overrun = r_rx_overrun;
  assign tbre       = r_tbre;
  assign tsre       = r_tsre;
  assign txd        = r_txd;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: serial-line TX monitor and bus-read monitor
// pop expectations queued by the stimulus; RX buffering checked against a queue model.
module tb_uart_bus_responder;

  localparam int DIV = 50_000_000 / 115_200;
`ifdef UART_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdn = 1'b1;
  logic        wrn = 1'b1;
  logic        rxd = 1'b1;
  logic        bus_drv = 1'b0;
  logic [15:0] bus_wval = 16'h0000;
  wire  [15:0] bus_data;
  logic        data_ready, tbre, tsre, txd, rx_overrun;

  assign bus_data = bus_drv ? bus_wval : 16'hzzzz;

  uart_bus_responder dut (
    .clk_50MHz  (clk),
    .rst        (rst),
    .bus_data   (bus_data),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .txd        (txd),
    .rxd        (rxd),
    .rx_overrun (rx_overrun)
  );

  always #10 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cycle   = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // scoreboards and reference model
  logic [7:0] tx_q[$];
  bit         tx_b2b_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] rx_model[$];
  bit         model_ovr = 1'b0;
  bit         tx_mon_en = 1'b0;
  bit         tx_busy   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // TX monitor: every frame must match the next queued byte bit-exactly, DIV cycles per bit
  initial begin
    logic        prev;
    logic [9:0]  bits;
    logic [7:0]  exp_b, got_b;
    bit          b2b;
    int          bad;
    int unsigned start_cyc, last_stop;
    prev      = 1'b1;
    last_stop = 0;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev === 1'b1 && txd === 1'b0) begin
        start_cyc = cycle;
        tx_busy   = 1'b1;
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: got a start bit, expected none (cycle %0d)", cycle);
          exp_b = 8'h00;
          b2b   = 1'b0;
        end else begin
          exp_b = tx_q.pop_front();
          b2b   = tx_b2b_q.pop_front();
        end
        bits  = {1'b1, exp_b, 1'b0};
        bad   = 0;
        got_b = 8'h00;
        for (int i = 0; i < 10; i++) begin
          for (int c = 0; c < DIV; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (txd !== bits[i]) bad++;
            if (c == DIV / 2 && i >= 1 && i <= 8) got_b[i-1] = txd;
          end
        end
        check("tx_frame_byte", {24'h0, got_b}, {24'h0, exp_b});
        check("tx_frame_bit_errors", bad, 0);
        if (b2b) check("tx_back_to_back_gap", start_cyc - last_stop, 1);
        last_stop = cycle;
        tx_busy   = 1'b0;
      end
      prev = txd;
    end
  end

  // Bus-read monitor: first cycle of each rdn low pulse compares bus_data with the queued byte
  initial begin
    logic       prev;
    logic [7:0] exp_b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && rdn === 1'b0) begin
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected_read: got bus 0x%0h, expected no read", bus_data);
        end else begin
          exp_b = rd_q.pop_front();
          check("rx_read_bus_data", {16'h0, bus_data}, {24'h0, exp_b});
        end
      end
      prev = rdn;
    end
  end

  task automatic cpu_write(input logic [7:0] b);
    logic [7:0] hi;
    hi = 8'($urandom_range(0, 255));
    @(posedge clk); #2;
    bus_wval = {hi, b};
    bus_drv  = 1'b1;
    wrn      = 1'b0;
    @(posedge clk); #2;
    wrn     = 1'b1;
    bus_drv = 1'b0;
    $display("[TB] write 0x%02h", b);
  endtask

  task automatic cpu_read();
    if (rx_model.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_read_plan: got empty model, expected a byte to read");
      return;
    end
    rd_q.push_back(rx_model.pop_front());
    model_ovr = 1'b0;
    @(posedge clk); #2;
    rdn = 1'b0;
    @(posedge clk); #2;
    rdn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rx_ready_after_read", {31'h0, data_ready}, {31'h0, rx_model.size() > 0});
    check("rx_overrun_after_read", {31'h0, rx_overrun}, {31'h0, model_ovr});
  endtask

  task automatic rx_send(input logic [7:0] b, input logic good_stop);
    logic [9:0] bits;
    bits = {good_stop, b, 1'b0};
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (DIV) @(posedge clk);
      #2;
    end
    rxd = 1'b1;
    if (!good_stop) begin
      repeat (DIV) @(posedge clk);
      #2;
    end
    if (good_stop) begin
      if (rx_model.size() < RX_CAP) rx_model.push_back(b);
      else                          model_ovr = 1'b1;
    end
    $display("[TB] rx frame 0x%02h stop=%0d", b, good_stop);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rx_data_ready", {31'h0, data_ready}, {31'h0, rx_model.size() > 0});
    check("rx_overrun", {31'h0, rx_overrun}, {31'h0, model_ovr});
  endtask

  task automatic wait_tx_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      if (tx_q.size() == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("tx_done_in_time", {31'h0, done}, 32'h1);
  endtask

  task automatic tx_single(input logic [7:0] b);
    tx_q.push_back(b);
    tx_b2b_q.push_back(1'b0);
    cpu_write(b);
    @(negedge clk);
    check("tx_tbre_after_write", {31'h0, tbre}, 32'h0);
    @(negedge clk);
    check("tx_tbre_after_load", {31'h0, tbre}, 32'h1);
    check("tx_tsre_busy", {31'h0, tsre}, 32'h0);
    wait_tx_done();
    repeat (3) @(negedge clk);
    check("tx_tsre_idle", {31'h0, tsre}, 32'h1);
    check("tx_line_idle", {31'h0, txd}, 32'h1);
  endtask

  initial begin
    logic [7:0] b1, b2, b3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_tbre", {31'h0, tbre}, 32'h1);
    check("reset_tsre", {31'h0, tsre}, 32'h1);
    check("reset_data_ready", {31'h0, data_ready}, 32'h0);
    check("reset_overrun", {31'h0, rx_overrun}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // asynchronous reset in the middle of a TX frame with a byte pending in RX
    rx_send(8'h96, 1'b1);
    cpu_write(8'($urandom_range(0, 255)));
    repeat (1000) @(posedge clk);
    #2;
    check("pre_reset_tsre_busy", {31'h0, tsre}, 32'h0);
    rst = 1'b0;
    #1;
    check("async_reset_txd", {31'h0, txd}, 32'h1);
    check("async_reset_tbre", {31'h0, tbre}, 32'h1);
    check("async_reset_tsre", {31'h0, tsre}, 32'h1);
    check("async_reset_data_ready", {31'h0, data_ready}, 32'h0);
    rx_model.delete();
    model_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tx_mon_en = 1'b1;

    // single transmissions
    tx_single(8'hA5);
    tx_single(8'($urandom_range(0, 255)));

    // second byte queued while shifting goes out with no gap; third is dropped
    b1 = 8'h55;
    b2 = 8'h0F;
    b3 = 8'($urandom_range(0, 255));
    tx_q.push_back(b1);
    tx_b2b_q.push_back(1'b0);
    tx_q.push_back(b2);
    tx_b2b_q.push_back(1'b1);
    cpu_write(b1);
    repeat (50) @(posedge clk);
    cpu_write(b2);
    @(negedge clk);
    check("tx_thr_held", {31'h0, tbre}, 32'h0);
    check("tx_tsre_while_shifting", {31'h0, tsre}, 32'h0);
    repeat (50) @(posedge clk);
    cpu_write(b3);
    @(negedge clk);
    check("tx_thr_still_held", {31'h0, tbre}, 32'h0);
    wait_tx_done();
    repeat (5) @(negedge clk);
    check("tx_tsre_after_pair", {31'h0, tsre}, 32'h1);

    // basic receive and read
    rx_send(8'h3C, 1'b1);
    cpu_read();

    // rxd glitch shorter than half a bit: no byte
    @(posedge clk); #2;
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rxd = 1'b1;
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    check("rx_glitch_no_byte", {31'h0, data_ready}, {31'h0, rx_model.size() > 0});

    // framing error: byte discarded
    rx_send(8'($urandom_range(0, 255)), 1'b0);

    // fill the buffer and overflow it by one byte
    for (int k = 0; k < RX_CAP + 1; k++) rx_send(8'($urandom_range(0, 255)), 1'b1);
    for (int k = 0; k < RX_CAP; k++) cpu_read();

    // randomized receive traffic with occasional bad stop bits and reads
    for (int k = 0; k < 3; k++) begin
      rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      if (rx_model.size() > 0 && $urandom_range(0, 1) == 1) cpu_read();
    end
    while (rx_model.size() > 0) cpu_read();

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got no end of test, expected finish before cycle 95000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
